// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of the 16x32 synchronous FIFO write port.
// NREQ producers use valid/ready handshakes; one owner at a time holds the
// port for up to BURST beats, then the grant rotates. Writes are suppressed
// while the FIFO reports full, and the owner keeps its grant through a stall.

module fifo_wr_arbiter_chk #(
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] grant,
  input  logic            busy,
  input  logic [4:0]      beat_cnt,
  input  logic            fifo_wr,
  input  logic            fifo_full
);
  // At most one owner at any time.
  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  // busy mirrors ownership.
  a_busy_grant: assert property (@(posedge clk) disable iff (rst) busy == (grant != {NREQ{1'b0}}));
  // A write never lands on a full FIFO.
  a_no_write_full: assert property (@(posedge clk) disable iff (rst) !(fifo_wr && fifo_full));
  // The stored beat count stays below the burst length.
  a_beat_range: assert property (@(posedge clk) disable iff (rst) beat_cnt < 5'(BURST));
endmodule

module fifo_wr_arbiter #(
  parameter int DW    = 32,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 fifo_full,
  output logic                 fifo_wr,
  output logic [DW-1:0]        fifo_din,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic [4:0]           beat_cnt
);
  localparam int              PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [4:0]      LAST_BEAT = 5'(BURST - 1);
  localparam logic [PW-1:0]   LAST_IDX  = PW'(NREQ - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // One-hot vector with a single bit set at idx.
  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NREQ-1:0] vec;
    vec      = {NREQ{1'b0}};
    vec[idx] = 1'b1;
    return vec;
  endfunction

  state_t            state_r;
  state_t            state_s;
  logic [NREQ-1:0]   grant_r;
  logic [NREQ-1:0]   grant_s;
  logic [PW-1:0]     last_r;
  logic [PW-1:0]     last_s;
  logic [4:0]        beat_cnt_r;
  logic [4:0]        beat_cnt_s;
  logic              busy_r;
  logic              busy_s;

  logic              any_valid_s;
  logic [PW-1:0]     sel_s;
  logic [PW-1:0]     cand_s;
  logic              in_grant_s;
  logic              owner_valid_s;
  logic [DW-1:0]     owner_data_s;
  logic              ready_s;
  logic              xfer_s;
  logic [DW-1:0]     din_s;

  // Round-robin search: first valid requester after the last owner, wrapping at NREQ-1.
  always_comb begin
    any_valid_s = 1'b0;
    sel_s       = last_r;
    cand_s      = last_r;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = PW'((int'(last_r) + k) % NREQ);
      if (!any_valid_s && req_valid[cand_s]) begin
        any_valid_s = 1'b1;
        sel_s       = cand_s;
      end else begin
        sel_s = sel_s;
      end
    end
  end

  // Owner-side handshake; last_r names the owner while in GRANT, and reset gates everything off.
  always_comb begin
    in_grant_s    = (state_r == GRANT) && !rst;
    owner_valid_s = req_valid[last_r];
    owner_data_s  = DW'(req_data >> (int'(last_r) * DW));
    if (in_grant_s) begin
      ready_s = !fifo_full;
      xfer_s  = owner_valid_s && !fifo_full;
      din_s   = owner_data_s;
    end else begin
      ready_s = 1'b0;
      xfer_s  = 1'b0;
      din_s   = {DW{1'b0}};
    end
  end

  // Next-state logic: arbitrate in IDLE, count beats and decide release in GRANT.
  always_comb begin
    state_s    = state_r;
    grant_s    = grant_r;
    last_s     = last_r;
    beat_cnt_s = beat_cnt_r;
    case (state_r)
      IDLE: begin
        if (any_valid_s) begin
          state_s    = GRANT;
          grant_s    = onehot(sel_s);
          last_s     = sel_s;
          beat_cnt_s = 5'd0;
        end else begin
          state_s    = IDLE;
          grant_s    = {NREQ{1'b0}};
          beat_cnt_s = 5'd0;
        end
      end
      GRANT: begin
        if (!owner_valid_s) begin
          // Owner went quiet: hand the port back without a transfer.
          state_s    = IDLE;
          grant_s    = {NREQ{1'b0}};
          beat_cnt_s = 5'd0;
        end else if (fifo_full) begin
          // Stall: owner keeps the grant and the count holds.
          state_s    = GRANT;
          beat_cnt_s = beat_cnt_r;
        end else if (beat_cnt_r == LAST_BEAT) begin
          // Final beat of the burst transfers now; force rotation.
          state_s    = IDLE;
          grant_s    = {NREQ{1'b0}};
          beat_cnt_s = 5'd0;
        end else begin
          state_s    = GRANT;
          beat_cnt_s = beat_cnt_r + 5'd1;
        end
      end
      default: begin
        state_s    = IDLE;
        grant_s    = {NREQ{1'b0}};
        beat_cnt_s = 5'd0;
      end
    endcase
    busy_s = (state_s == GRANT);
  end

  // State, grant, pointer and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      grant_r    <= {NREQ{1'b0}};
      last_r     <= LAST_IDX;
      beat_cnt_r <= 5'd0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      grant_r    <= grant_s;
      last_r     <= last_s;
      beat_cnt_r <= beat_cnt_s;
      busy_r     <= busy_s;
    end
  end

  assign req_ready = grant_r & {NREQ{ready_s}};
  assign fifo_wr   = xfer_s;
  assign fifo_din  = din_s;
  assign grant     = grant_r;
  assign busy      = busy_r;
  assign beat_cnt  = beat_cnt_r;

  fifo_wr_arbiter_chk #(
    .NREQ  (NREQ),
    .BURST (BURST)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .grant     (grant_r),
    .busy      (busy_r),
    .beat_cnt  (beat_cnt_r),
    .fifo_wr   (xfer_s),
    .fifo_full (fifo_full)
  );

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomised bench for fifo_wr_arbiter (DW=32, NREQ=4, BURST=4).
module tb_fifo_wr_arbiter;
  localparam int DW = 32;
  localparam int NREQ = 4;
  localparam int BURST = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              fifo_full;
  logic              fifo_wr;
  logic [DW-1:0]     fifo_din;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic [4:0]        beat_cnt;

  int checks = 0;
  int errors = 0;
  int n [NREQ];
  int mode;
  logic            last_wr;
  logic [31:0]     last_din;
  logic [NREQ-1:0] last_x;
  logic            last_full;
  logic [NREQ-1:0] last_grant;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DW(DW), .NREQ(NREQ), .BURST(BURST)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .fifo_full (fifo_full),
    .fifo_wr   (fifo_wr),
    .fifo_din  (fifo_din),
    .grant     (grant),
    .busy      (busy),
    .beat_cnt  (beat_cnt)
  );

  // Producer data for requester i, beat k.
  function automatic logic [31:0] data_of(int i, int k);
    logic [31:0] tbl [5];
    tbl = '{32'd100, 32'd150, 32'd10, 32'd15, 32'd1};
    if (mode == 0) return (k < 5) ? tbl[k] : 32'd0;
    else if (mode == 1) return 32'(i * 1000 + k);
    else return 32'(i * 65536 + k);
  endfunction

  task automatic drive_data();
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = data_of(i, n[i]);
  endtask

  // One clock: sample outputs at the negedge, advance producers that handshook.
  task automatic step();
    @(negedge clk);
    last_wr = fifo_wr; last_din = fifo_din; last_x = req_valid & req_ready;
    last_full = fifo_full; last_grant = grant;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (last_x[i]) n[i]++;
    drive_data();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 4'b0000; fifo_full = 1'b0;
    for (int i = 0; i < NREQ; i++) n[i] = 0;
    drive_data();
    step(); step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    mode = 1;
    do_reset();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (beat_cnt !== 5'd0) begin errors++; $display("FAIL reset_beat got %0d want 0", beat_cnt); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    checks++; if (fifo_wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %b want 0", fifo_wr); end
  endtask

  task automatic test_single();
    logic [31:0] exp_d [4];
    exp_d = '{32'd100, 32'd150, 32'd10, 32'd15};
    mode = 0;
    do_reset();
    req_valid = 4'b0001; drive_data(); #1;
    step();
    checks++; if (last_wr !== 1'b0) begin errors++; $display("FAIL single_idle_wr got %b want 0", last_wr); end
    checks++; if (grant !== 4'b0001 || busy !== 1'b1) begin errors++; $display("FAIL single_grant got %b/%b want 0001/1", grant, busy); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (beat_cnt !== 5'(k)) begin errors++; $display("FAIL single_beat%0d got %0d want %0d", k, beat_cnt, k); end
      step();
      checks++; if (last_wr !== 1'b1 || last_din !== exp_d[k]) begin errors++; $display("FAIL single_data%0d got wr=%b %0d want wr=1 %0d", k, last_wr, last_din, exp_d[k]); end
    end
    checks++; if (grant !== 4'b0000 || beat_cnt !== 5'd0) begin errors++; $display("FAIL single_release got %b/%0d want 0000/0", grant, beat_cnt); end
    step();
    checks++; if (last_wr !== 1'b0) begin errors++; $display("FAIL single_gap_wr got %b want 0", last_wr); end
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_regrant got %b want 0001", grant); end
    step();
    checks++; if (last_wr !== 1'b1 || last_din !== 32'd1) begin errors++; $display("FAIL single_regrant_data got wr=%b %0d want wr=1 1", last_wr, last_din); end
    req_valid = 4'b0000; step();
  endtask

  task automatic test_round_robin();
    mode = 1;
    do_reset();
    req_valid = 4'b1111; drive_data(); #1;
    for (int b = 0; b < 5; b++) begin
      int g;
      g = b % 4;
      step();
      checks++; if (last_wr !== 1'b0) begin errors++; $display("FAIL rr_gap%0d_wr got %b want 0", b, last_wr); end
      checks++; if (grant !== (4'b0001 << g)) begin errors++; $display("FAIL rr_grant%0d got %b want %b", b, grant, 4'b0001 << g); end
      for (int k = 0; k < 4; k++) begin
        checks++; if (req_ready !== grant) begin errors++; $display("FAIL rr_ready%0d_%0d got %b want %b", b, k, req_ready, grant); end
        step();
        checks++; if (last_wr !== 1'b1 || last_din !== 32'(g * 1000 + (b / 4) * 4 + k)) begin
          errors++; $display("FAIL rr_data%0d_%0d got wr=%b %0d want wr=1 %0d", b, k, last_wr, last_din, g * 1000 + (b / 4) * 4 + k);
        end
      end
    end
  endtask

  task automatic test_full_stall();
    mode = 1;
    do_reset();
    req_valid = 4'b0100; drive_data(); #1;
    step();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL stall_grant got %b want 0100", grant); end
    step(); step();
    checks++; if (last_din !== 32'd2001 || beat_cnt !== 5'd2) begin errors++; $display("FAIL stall_pre got %0d/%0d want 2001/2", last_din, beat_cnt); end
    fifo_full = 1'b1; #1;
    checks++; if (req_ready !== 4'b0000 || fifo_wr !== 1'b0) begin errors++; $display("FAIL stall_comb got %b/%b want 0000/0", req_ready, fifo_wr); end
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (last_wr !== 1'b0 || beat_cnt !== 5'd2 || grant !== 4'b0100) begin
        errors++; $display("FAIL stall_hold%0d got wr=%b beat=%0d grant=%b want 0/2/0100", c, last_wr, beat_cnt, grant);
      end
    end
    fifo_full = 1'b0; #1;
    step();
    checks++; if (last_wr !== 1'b1 || last_din !== 32'd2002 || beat_cnt !== 5'd3) begin errors++; $display("FAIL stall_resume3 got wr=%b %0d beat=%0d want 1/2002/3", last_wr, last_din, beat_cnt); end
    step();
    checks++; if (last_wr !== 1'b1 || last_din !== 32'd2003) begin errors++; $display("FAIL stall_resume4 got wr=%b %0d want 1/2003", last_wr, last_din); end
    checks++; if (grant !== 4'b0000 || beat_cnt !== 5'd0) begin errors++; $display("FAIL stall_release got %b/%0d want 0000/0", grant, beat_cnt); end
  endtask

  task automatic test_owner_drop();
    mode = 1;
    do_reset();
    req_valid = 4'b1010; drive_data(); #1;
    step();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL drop_grant got %b want 0010", grant); end
    step();
    checks++; if (last_din !== 32'd1000 || beat_cnt !== 5'd1) begin errors++; $display("FAIL drop_beat got %0d/%0d want 1000/1", last_din, beat_cnt); end
    req_valid = 4'b1000; #1;
    step();
    checks++; if (last_wr !== 1'b0) begin errors++; $display("FAIL drop_wr got %b want 0", last_wr); end
    checks++; if (grant !== 4'b0000 || beat_cnt !== 5'd0) begin errors++; $display("FAIL drop_release got %b/%0d want 0000/0", grant, beat_cnt); end
    step();
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL drop_next_grant got %b want 1000", grant); end
    step();
    checks++; if (last_wr !== 1'b1 || last_din !== 32'd3000) begin errors++; $display("FAIL drop_next_data got wr=%b %0d want 1/3000", last_wr, last_din); end
  endtask

  task automatic test_reset_mid_burst();
    mode = 1;
    do_reset();
    req_valid = 4'b0001; drive_data(); #1;
    step(); step(); step();
    checks++; if (beat_cnt !== 5'd2 || grant !== 4'b0001) begin errors++; $display("FAIL mid_pre got %0d/%b want 2/0001", beat_cnt, grant); end
    rst = 1'b1; req_valid = 4'b1101; #1;
    checks++; if (req_ready !== 4'b0000 || fifo_wr !== 1'b0) begin errors++; $display("FAIL mid_rst_comb got %b/%b want 0000/0", req_ready, fifo_wr); end
    step();
    rst = 1'b0; #1;
    checks++; if (grant !== 4'b0000 || busy !== 1'b0 || beat_cnt !== 5'd0 || fifo_wr !== 1'b0) begin
      errors++; $display("FAIL mid_after got grant=%b busy=%b beat=%0d wr=%b want 0000/0/0/0", grant, busy, beat_cnt, fifo_wr);
    end
    checks++; if (n[0] !== 2) begin errors++; $display("FAIL mid_no_accept got %0d beats want 2", n[0]); end
    step();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL mid_regrant got %b want 0001", grant); end
    step();
    checks++; if (last_wr !== 1'b1 || last_din !== 32'd2) begin errors++; $display("FAIL mid_data got wr=%b %0d want 1/2", last_wr, last_din); end
  endtask

  task automatic test_random();
    logic [31:0] q [$];
    logic [31:0] d;
    int sent [NREQ];
    int got [NREQ];
    int r;
    mode = 2;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin sent[i] = 0; got[i] = 0; end
    for (int cyc = 0; cyc < 5000; cyc++) begin
      for (int i = 0; i < NREQ; i++) if (!req_valid[i]) req_valid[i] = ($urandom_range(0, 99) < 60);
      fifo_full = (q.size() >= 16);
      #1;
      step();
      checks++; if (last_wr && last_full) begin errors++; $display("FAIL rnd_write_full cyc %0d got wr=1 want 0", cyc); end
      checks++; if (!$onehot0(last_grant)) begin errors++; $display("FAIL rnd_onehot cyc %0d got %b want onehot0", cyc, last_grant); end
      checks++; if (last_wr !== (last_x != 4'b0000)) begin errors++; $display("FAIL rnd_wr_vs_hs cyc %0d got wr=%b hs=%b", cyc, last_wr, last_x); end
      if (last_wr) q.push_back(last_din);
      for (int i = 0; i < NREQ; i++) begin
        if (last_x[i]) begin
          sent[i]++;
          req_valid[i] = ($urandom_range(0, 99) < 70);
        end
      end
      if (q.size() > 0 && $urandom_range(0, 99) < 40) begin
        d = q.pop_front(); r = int'(d[31:16]);
        checks++;
        if (r >= NREQ) begin errors++; $display("FAIL rnd_src got %0d want <4", r); end
        else if (d[15:0] !== 16'(got[r])) begin errors++; $display("FAIL rnd_order req%0d got %0d want %0d", r, d[15:0], got[r]); got[r]++; end
        else got[r]++;
      end
    end
    req_valid = 4'b0000;
    while (q.size() > 0) begin
      d = q.pop_front(); r = int'(d[31:16]);
      checks++;
      if (r >= NREQ) begin errors++; $display("FAIL rnd_src got %0d want <4", r); end
      else if (d[15:0] !== 16'(got[r])) begin errors++; $display("FAIL rnd_order req%0d got %0d want %0d", r, d[15:0], got[r]); got[r]++; end
      else got[r]++;
    end
    for (int i = 0; i < NREQ; i++) begin
      checks++; if (got[i] !== sent[i] || sent[i] == 0) begin errors++; $display("FAIL rnd_count req%0d got %0d want %0d (nonzero)", i, got[i], sent[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_owner_drop();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
